game_input_conditioner: RTL and testbench
=========================================

# game_input_conditioner

Conditions the raw board push-button and the 2-bit switch bank before they reach `game_top` (drives its `key` and `sw` inputs). Each input is double-flop synchronised and debounced by a stability counter. The button additionally gets press/release edge pulses and a hold-to-repeat generator, so the master FSM sees one clean event per physical press.

## Interface
- `DEBOUNCE_CYCLES`, 50000: consecutive differing synchronised samples required before a debounced level flips; must be ≥ 1.
- `REPEAT_DELAY`, 25000000: cycles from press pulse to first repeat pulse; 0 disables repeat.
- `REPEAT_PERIOD`, 6250000: cycles between subsequent repeat pulses; must be ≥ 1.
- `KEY_ACTIVE_LOW`, 1: 1 = pin reads 0 when pressed.
- `COUNTER_WIDTH`, 26: width of the debounce and repeat counters; all cycle parameters must fit.

- `clk`  in  1  system clock, the single clock.
- `reset`  in  1  synchronous, active-low reset (asserted when 0, sampled on `clk` rising edge).
- `key_pin`  in  1  raw asynchronous button.
- `sw_pin`  in  2  raw asynchronous switches.
- `key`  out  1  debounced pressed level, active-high; feeds `game_top.key`.
- `key_press`  out  1  one-cycle pulse when `key` rises.
- `key_release`  out  1  one-cycle pulse when `key` falls.
- `key_repeat`  out  1  one-cycle auto-repeat pulse while held.
- `sw`  out  2  debounced switches; feeds `game_top.sw`.
- `sw_changed`  out  1  one-cycle pulse when any `sw` bit flips.

## Operation
- Synchronisers: two flops per input bit. Reset value of key flops = inactive pin level (1 if `KEY_ACTIVE_LOW`, else 0); sw flops reset to 0. Polarity inversion is applied after the second flop.
- Debounce, per bit (key, sw[0], sw[1], independent counters): if synchronised sample equals debounced level, counter ← 0. Else if counter = `DEBOUNCE_CYCLES`−1, level ← sample, counter ← 0. Else counter ← counter+1. A single agreeing sample restarts the count.
- `key_press`/`key_release`: registered, asserted in the same cycle `key` first shows its new value; never both high.
- `sw_changed`: registered, asserted in the same cycle `sw` first shows a new value; both bits flipping together give one pulse.
- Repeat FSM, states IDLE, DELAY, REPEAT; repeat counter `rc`:
  - IDLE: on key rise, go to DELAY with `rc` ← 0, but stay in IDLE if `REPEAT_DELAY` = 0.
  - DELAY: if `key` falls, go to IDLE. Else if `rc` = `REPEAT_DELAY`−1, pulse `key_repeat`, go to REPEAT, `rc` ← 0. Else `rc` ← `rc`+1.
  - REPEAT: if `key` falls, go to IDLE. Else if `rc` = `REPEAT_PERIOD`−1, pulse `key_repeat`, `rc` ← 0. Else `rc` ← `rc`+1.
  - Release has priority over a coincident repeat terminal count: no `key_repeat` in the `key_release` cycle.
- Reset while asserted, including mid-debounce or mid-repeat: all counters 0, FSM IDLE, every output 0.

## Timing
- All outputs registered; no combinational path from a pin to an output.
- Every output resets to 0. Sync flops reset to their inactive values.
- Pin stable at its new value from before edge 0: `key`/`sw` flips at edge `DEBOUNCE_CYCLES`+2; the pulse appears at the same edge.
- Glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles: no output change.
- First `key_repeat` comes `REPEAT_DELAY` cycles after `key_press`; subsequent ones every `REPEAT_PERIOD` cycles.
- Throughput: new press accepted immediately after release debounce; no dead time beyond `DEBOUNCE_CYCLES`.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3, `KEY_ACTIVE_LOW`=1.
- Reset: hold `reset`=0 for 3 cycles with `key_pin`=0 → all outputs 0; release reset with `key_pin`=1 → outputs stay 0 indefinitely.
- Clean press: `key_pin` 1→0 before edge 0 → `key`=1 and `key_press`=1 at edge 6; `key_press`=0 at edge 7.
- Bounce: `key_pin` low 3 cycles, high 1 cycle, low again → `key` rises only 4 synchronised low samples after the last bounce; exactly one `key_press`.
- Hold: press held 30 cycles after `key_press` → `key_repeat` at +10, +13, +16, … +28 (7 pulses). Release → `key_release` one pulse, no further repeats.
- Release on terminal count: release timed so `key` falls on a repeat edge → `key_release`=1, `key_repeat`=0 that cycle; FSM in IDLE.
- Switches: `sw_pin` 00→11 simultaneously → `sw`=11 at edge 6 with a single `sw_changed`. A 2-cycle glitch on `sw_pin[0]` → no change. Reset asserted mid-debounce → counters cleared, `sw`=00.

Source files
------------

// File: rtl/game_input_if.sv
// ----------------------------------------------------------------------------
// game_input_if
//   Bundles the raw board inputs and the conditioned outputs that feed
//   game_top.
//
//   Signals:
//     key_pin      raw asynchronous push-button
//     sw_pin[1:0]  raw asynchronous switch bank
//     key          debounced pressed level, active-high
//     key_press    one-cycle pulse when key rises
//     key_release  one-cycle pulse when key falls
//     key_repeat   one-cycle auto-repeat pulse while the button is held
//     sw[1:0]      debounced switches
//     sw_changed   one-cycle pulse when any sw bit flips
//
//   Modports:
//     master  board side: drives the pins, observes the conditioned outputs
//     slave   conditioner side: reads the pins, drives the conditioned outputs
// ----------------------------------------------------------------------------
interface game_input_if;
    logic       key_pin;
    logic [1:0] sw_pin;
    logic       key;
    logic       key_press;
    logic       key_release;
    logic       key_repeat;
    logic [1:0] sw;
    logic       sw_changed;

    modport master (
        output key_pin, sw_pin,
        input  key, key_press, key_release, key_repeat, sw, sw_changed
    );

    modport slave (
        input  key_pin, sw_pin,
        output key, key_press, key_release, key_repeat, sw, sw_changed
    );
endinterface

// File: rtl/game_input_conditioner.sv
// ----------------------------------------------------------------------------
// game_input_conditioner
//   Synchronises and debounces the board push-button and 2-bit switch bank,
//   then derives press/release pulses, a hold-to-repeat pulse and a switch
//   change pulse, so game_top sees one clean event per physical action.
//
//   Ports:
//     clk    system clock
//     reset  synchronous, active-low reset
//     bus    game_input_if.slave: raw pins in, conditioned outputs out
//
//   Pipeline: pin -> sync1 -> sync2 -> debounce level -> registered outputs.
//   A pin change stable before edge 0 shows on key/sw at edge
//   DEBOUNCE_CYCLES+2, together with its pulse.
// ----------------------------------------------------------------------------
module game_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 6250000,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1,
    parameter int unsigned COUNTER_WIDTH   = 26
) (
    input  logic        clk,
    input  logic        reset,
    game_input_if.slave bus
);

    // Bit 0 is the key, bits 2:1 are the switches.
    localparam logic [2:0] SYNC_RST = {2'b00, KEY_ACTIVE_LOW};

    localparam logic [COUNTER_WIDTH-1:0] DB_LAST = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] RD_LAST = COUNTER_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [COUNTER_WIDTH-1:0] RP_LAST = COUNTER_WIDTH'(REPEAT_PERIOD - 1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);
    localparam bit                       REPEAT_EN = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rep_state_t;

    logic [2:0]               sync1;
    logic [2:0]               sync2;
    logic [2:0]               sample;
    logic [2:0]               level;
    logic [COUNTER_WIDTH-1:0] db_cnt [3];

    logic       key_q;
    logic       key_press_q;
    logic       key_release_q;
    logic       key_repeat_q;
    logic [1:0] sw_q;
    logic       sw_changed_q;

    rep_state_t               state;
    rep_state_t               state_next;
    logic [COUNTER_WIDTH-1:0] rc;
    logic [COUNTER_WIDTH-1:0] rc_next;
    logic                     repeat_next;
    logic                     key_rise;
    logic                     key_fall;

    // Polarity correction after the second flop, so the debouncer always
    // works on an active-high key.
    assign sample = {sync2[2:1], sync2[0] ^ KEY_ACTIVE_LOW};

    // ------------------------------------------------------------------
    // Synchronisers and per-bit stability counters
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (sync2 sees old sync1).
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= SYNC_RST;
            sync2 <= SYNC_RST;
            level <= '0;
            // NOTE: the counter array is only three registers, so it is
            // reset explicitly; a mid-debounce reset must restart counting.
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= {bus.sw_pin, bus.key_pin};
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                if (sample[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sample[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // The output stage lags the debounced level by one cycle, so a
    // mismatch between them is exactly the cycle an edge is published.
    assign key_rise = level[0] & ~key_q;
    assign key_fall = ~level[0] & key_q;

    // ------------------------------------------------------------------
    // Repeat FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a
        // signal unassigned and infers a latch.
        state_next  = state;
        rc_next     = rc;
        repeat_next = 1'b0;
        case (state)
            IDLE: begin
                if (key_rise && REPEAT_EN) begin
                    state_next = DELAY;
                    rc_next    = '0;
                end
            end
            DELAY: begin
                // Release wins over a coincident terminal count.
                if (key_fall) begin
                    state_next = IDLE;
                    rc_next    = '0;
                end else if (rc == RD_LAST) begin
                    repeat_next = 1'b1;
                    state_next  = REPEAT;
                    rc_next     = '0;
                end else begin
                    rc_next = rc + CNT_ONE;
                end
            end
            REPEAT: begin
                if (key_fall) begin
                    state_next = IDLE;
                    rc_next    = '0;
                end else if (rc == RP_LAST) begin
                    repeat_next = 1'b1;
                    rc_next     = '0;
                end else begin
                    rc_next = rc + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                rc_next    = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            rc            <= '0;
            key_q         <= 1'b0;
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
            key_repeat_q  <= 1'b0;
            sw_q          <= 2'b00;
            sw_changed_q  <= 1'b0;
        end else begin
            state         <= state_next;
            rc            <= rc_next;
            key_q         <= level[0];
            key_press_q   <= key_rise;
            key_release_q <= key_fall;
            key_repeat_q  <= repeat_next;
            sw_q          <= level[2:1];
            sw_changed_q  <= (level[2:1] != sw_q);
        end
    end

    assign bus.key         = key_q;
    assign bus.key_press   = key_press_q;
    assign bus.key_release = key_release_q;
    assign bus.key_repeat  = key_repeat_q;
    assign bus.sw          = sw_q;
    assign bus.sw_changed  = sw_changed_q;

endmodule

// File: tb/tb_game_input_conditioner.sv
// ----------------------------------------------------------------------------
// tb_game_input_conditioner
//   Directed stimulus against game_input_conditioner with a small timeline
//   model: the debouncer sees the pin two edges late, a level flips after
//   DEBOUNCE_CYCLES consecutive differing samples, outputs appear one edge
//   after the flip, and repeats fall at REPEAT_DELAY + k*REPEAT_PERIOD edges
//   after the press while the key is still held.
// ----------------------------------------------------------------------------
module tb_game_input_conditioner;

    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    game_input_if bus ();

    game_input_conditioner #(
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .KEY_ACTIVE_LOW  (1'b1),
        .COUNTER_WIDTH   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model state ----------------
    logic [2:0] m_hist [$];   // active-high {sw, key} samples still in flight
    logic [2:0] m_lvl;
    int         m_run [3];
    logic       m_key, m_press, m_release, m_repeat, m_swc;
    logic [1:0] m_sw;
    int         m_press_cyc;

    // ---------------- observations of the DUT ----------------
    int press_count, release_count, repeat_count, swc_count;
    int last_press_cyc, last_release_cyc, last_swc_cyc;
    logic repeat_at_release;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        logic [2:0] old_lvl;
        logic [2:0] smp;
        logic       old_key;
        logic [1:0] old_sw;
        int         el;
        if (!reset) begin
            m_hist    = '{3'b000, 3'b000};
            m_lvl     = '0;
            m_run     = '{0, 0, 0};
            m_key     = 0; m_press = 0; m_release = 0; m_repeat = 0;
            m_sw      = 2'b00; m_swc = 0;
        end else begin
            old_lvl = m_lvl;
            old_key = m_key;
            old_sw  = m_sw;
            smp = m_hist.pop_front();
            m_hist.push_back({bus.sw_pin, ~bus.key_pin});
            for (int i = 0; i < 3; i++) begin
                if (smp[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC) begin
                        m_lvl[i] = smp[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_key     = old_lvl[0];
            m_press   = old_lvl[0] & ~old_key;
            m_release = ~old_lvl[0] & old_key;
            m_sw      = old_lvl[2:1];
            m_swc     = (old_lvl[2:1] != old_sw);
            if (m_press) m_press_cyc = cyc;
            m_repeat = 0;
            if (m_key && !m_press && RD != 0) begin
                el = cyc - m_press_cyc;
                if (el >= RD && ((el - RD) % RP) == 0) m_repeat = 1;
            end
        end
    endtask

    // One compare process: update the model at each edge, check 1 ns later.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            #1;
            check("key",         bus.key,         m_key);
            check("key_press",   bus.key_press,   m_press);
            check("key_release", bus.key_release, m_release);
            check("key_repeat",  bus.key_repeat,  m_repeat);
            check("sw",          bus.sw,          m_sw);
            check("sw_changed",  bus.sw_changed,  m_swc);
            if (bus.key_press)   begin press_count++;   last_press_cyc = cyc; end
            if (bus.key_repeat)  repeat_count++;
            if (bus.key_release) begin
                release_count++;
                last_release_cyc  = cyc;
                repeat_at_release = bus.key_repeat;
            end
            if (bus.sw_changed)  begin swc_count++; last_swc_cyc = cyc; end
        end
    end

    // Return at the falling edge after edge e, so new pin values land before edge e+1.
    task automatic wait_until(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    int t0;

    initial begin
        checks = 0; errors = 0;
        press_count = 0; release_count = 0; repeat_count = 0; swc_count = 0;
        last_press_cyc = 0; last_release_cyc = 0; last_swc_cyc = 0;
        repeat_at_release = 0;
        reset = 1'b0;
        bus.key_pin = 1'b0;
        bus.sw_pin  = 2'b00;

        // Reset held three edges with the pin reading "pressed".
        wait_until(3);
        check("rst_key", bus.key, 1'b0);
        check("rst_sw",  bus.sw,  2'b00);
        reset = 1'b1;
        bus.key_pin = 1'b1;
        wait_until(15);
        check("idle_key",    bus.key,     1'b0);
        check("idle_events", press_count, 0);

        // Clean press held until key falls 30 edges after key_press.
        repeat_count = 0; release_count = 0;
        bus.key_pin = 1'b0;
        t0 = cyc + 1;
        wait_until(t0 + 7);
        check("press_latency",       last_press_cyc - t0, 6);
        check("model_press_latency", m_press_cyc - t0,    6);
        check("press_key_level",     bus.key,             1'b1);
        wait_until(t0 + 29);
        bus.key_pin = 1'b1;
        wait_until(t0 + 50);
        check("hold_repeat_count", repeat_count,                     7);
        check("hold_release_pos",  last_release_cyc - last_press_cyc, 30);
        check("hold_release_cnt",  release_count,                    1);

        // Release whose key fall lands on a repeat terminal edge (+13).
        repeat_count = 0;
        bus.key_pin = 1'b0;
        t0 = cyc + 1;
        wait_until(t0 + 12);
        bus.key_pin = 1'b1;
        wait_until(t0 + 45);
        check("term_release_pos", last_release_cyc - last_press_cyc, 13);
        check("term_no_repeat",   repeat_at_release,                 1'b0);
        check("term_repeat_cnt",  repeat_count,                      1);

        // Bounce: low 3 edges, high 1, then low for good.
        press_count = 0;
        bus.key_pin = 1'b0;
        t0 = cyc + 1;
        wait_until(t0 + 2);
        bus.key_pin = 1'b1;
        wait_until(t0 + 3);
        bus.key_pin = 1'b0;
        wait_until(t0 + 16);
        check("bounce_presses", press_count,                1);
        check("bounce_latency", last_press_cyc - (t0 + 4),  6);
        bus.key_pin = 1'b1;
        wait_until(t0 + 40);

        // Both switches flip together.
        swc_count = 0;
        bus.sw_pin = 2'b11;
        t0 = cyc + 1;
        wait_until(t0 + 8);
        check("sw_value",   bus.sw,            2'b11);
        check("sw_pulses",  swc_count,         1);
        check("sw_latency", last_swc_cyc - t0, 6);

        // Two-edge glitch on sw_pin[0].
        swc_count = 0;
        bus.sw_pin = 2'b10;
        t0 = cyc + 1;
        wait_until(t0 + 1);
        bus.sw_pin = 2'b11;
        wait_until(t0 + 12);
        check("glitch_pulses", swc_count, 0);
        check("glitch_sw",     bus.sw,    2'b11);

        // Reset in the middle of a switch debounce.
        bus.sw_pin = 2'b00;
        t0 = cyc + 1;
        wait_until(t0 + 3);
        reset = 1'b0;
        wait_until(t0 + 5);
        check("rst_mid_sw", bus.sw, 2'b00);
        reset = 1'b1;
        wait_until(t0 + 15);
        check("post_rst_sw", bus.sw, 2'b00);

        // Reset while the repeat generator is running, key still held after.
        bus.key_pin = 1'b0;
        t0 = cyc + 1;
        wait_until(t0 + 20);
        reset = 1'b0;
        wait_until(t0 + 22);
        check("rst_mid_rep_key", bus.key, 1'b0);
        reset = 1'b1;
        wait_until(t0 + 40);
        bus.key_pin = 1'b1;
        wait_until(t0 + 55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
